// File: rtl/inst_encoder.sv
// inst_encoder: packs RISC-V instruction fields and an unpacked immediate into
// a 32-bit instruction word, buffered through a DEPTH-entry output FIFO.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN;
// without it only an undefined immediate type raises imm_err.

`ifndef Imm_type_num_log2
`define Imm_type_num_log2 4
`define Imm_no      4'd0
`define Imm_I_type  4'd1
`define Imm_I_shift 4'd2
`define Imm_S_type  4'd3
`define Imm_B_type  4'd4
`define Imm_U_type  4'd5
`define Imm_J_type  4'd6
`define Imm_CSR     4'd7
`endif

module inst_encoder #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [`Imm_type_num_log2-1:0] imm_type,
  input  logic [31:0]                   imm,
  input  logic [6:0]                    opcode,
  input  logic [4:0]                    rd,
  input  logic [4:0]                    rs1,
  input  logic [4:0]                    rs2,
  input  logic [2:0]                    funct3,
  input  logic [6:0]                    funct7,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   instr,
  output logic                          imm_err,
  output logic [15:0]                   enc_cnt,
  output logic [15:0]                   err_cnt
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic [31:0]   r_mem_instr [DEPTH];
  logic          r_mem_err   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [31:0]   r_instr;
  logic          r_imm_err;
  logic [15:0]   r_enc_cnt;
  logic [15:0]   r_err_cnt;

  logic [31:0]   w_enc_instr;
  logic          w_undef;
  logic          w_range_err;
  logic          w_enc_err;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_rd_next;
  logic          w_head_is_new;
  logic [31:0]   w_head_instr;
  logic          w_head_err;

  // Field packing and immediate representability per immediate format
  always_comb begin
    w_enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
    w_undef     = 1'b0;
    w_range_err = 1'b0;
    case (imm_type)
      `Imm_no: begin
        w_enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      `Imm_I_type: begin
        w_enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        w_range_err = (imm[31:11] != {21{imm[11]}});
      end
      `Imm_I_shift: begin
        w_enc_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        w_range_err = (imm[31:5] != 27'd0);
      end
      `Imm_S_type: begin
        w_enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_range_err = (imm[31:11] != {21{imm[11]}});
      end
      `Imm_B_type: begin
        w_enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_range_err = (imm[31:12] != {20{imm[12]}}) | imm[0];
      end
      `Imm_U_type: begin
        w_enc_instr = {imm[31:12], rd, opcode};
        w_range_err = (imm[11:0] != 12'd0);
      end
      `Imm_J_type: begin
        w_enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_range_err = (imm[31:20] != {12{imm[20]}}) | imm[0];
      end
      `Imm_CSR: begin
        w_enc_instr = {funct7, rs2, imm[4:0], funct3, rd, opcode};
        w_range_err = (imm[31:5] != 27'd0);
      end
      default: begin
        w_undef = 1'b1;
      end
    endcase
    w_enc_err = w_undef | (RANGE_CHK & w_range_err);
  end

  // Handshake, next occupancy and the word that will sit at the head next cycle
  always_comb begin
    w_push        = in_valid & r_in_ready;
    w_pop         = r_out_valid & out_ready;
    w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
    w_rd_next     = r_rd_ptr + AW'(w_pop);
    w_head_is_new = w_push && (w_rd_next == r_wr_ptr);
    w_head_instr  = w_head_is_new ? w_enc_instr : r_mem_instr[w_rd_next];
    w_head_err    = w_head_is_new ? w_enc_err   : r_mem_err[w_rd_next];
  end

  // Buffer storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_instr[r_wr_ptr] <= w_enc_instr;
      r_mem_err[r_wr_ptr]   <= w_enc_err;
    end
  end

  // Pointers, occupancy, registered outputs and pop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_imm_err   <= 1'b0;
      r_enc_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_in_ready  <= (w_count_next < CW'(DEPTH));
      r_out_valid <= (w_count_next != '0);
      r_instr     <= (w_count_next != '0) ? w_head_instr : 32'd0;
      r_imm_err   <= (w_count_next != '0) ? w_head_err : 1'b0;
      if (w_pop) begin
        r_enc_cnt <= r_enc_cnt + 16'd1;
        if (r_imm_err) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign instr     = r_instr;
  assign imm_err   = r_imm_err;
  assign enc_cnt   = r_enc_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (DEPTH=2).

`ifndef Imm_type_num_log2
`define Imm_type_num_log2 4
`define Imm_no      4'd0
`define Imm_I_type  4'd1
`define Imm_I_shift 4'd2
`define Imm_S_type  4'd3
`define Imm_B_type  4'd4
`define Imm_U_type  4'd5
`define Imm_J_type  4'd6
`define Imm_CSR     4'd7
`endif

module tb_inst_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [3:0]  t;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [`Imm_type_num_log2-1:0] imm_type;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        imm_err;
  logic [15:0] enc_cnt;
  logic [15:0] err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  inst_encoder #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm_type(imm_type), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .imm_err(imm_err),
    .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    imm_type = v.t;
    imm      = v.imm;
    opcode   = v.op;
    rd       = v.rd;
    rs1      = v.rs1;
    rs2      = v.rs2;
    funct3   = v.f3;
    funct7   = v.f7;
  endtask

  function automatic vec_t mk(input logic [3:0] t, input logic [31:0] im,
                              input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.t = t; v.imm = im; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.f3 = f3; v.f7 = f7; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(`Imm_no, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(); step();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", instr); end
    n_cmp++; if (imm_err !== 1'b0) begin n_fail++; $display("FAIL rst_imm_err got %b exp 0", imm_err); end
    n_cmp++; if (enc_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_enc_cnt got %0d exp 0", enc_cnt); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); end
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_encodings();
    vec_t v [11];
    logic [15:0] exp_enc;
    logic [15:0] exp_errc;
    v[0]  = mk(`Imm_I_type,  32'hFFFFFFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00093, 1'b0);
    v[1]  = mk(`Imm_B_type,  32'hFFFFFFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFE000EE3, 1'b0);
    v[2]  = mk(`Imm_J_type,  32'h00000008, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h008000EF, 1'b0);
    v[3]  = mk(`Imm_U_type,  32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h123452B7, 1'b0);
    v[4]  = mk(`Imm_U_type,  32'h12345001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h123452B7, CHK);
    v[5]  = mk(`Imm_no,      32'h00000000, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h403100B3, 1'b0);
    v[6]  = mk(`Imm_S_type,  32'h00000008, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'h00512423, 1'b0);
    v[7]  = mk(`Imm_I_shift, 32'h00000003, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'h40315093, 1'b0);
    v[8]  = mk(`Imm_CSR,     32'h00000002, 7'h73, 5'd1, 5'd0, 5'd5, 3'd1, 7'h18, 32'h305110F3, 1'b0);
    v[9]  = mk(`Imm_I_type,  32'h00000800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h80000093, CHK);
    v[10] = mk(4'hF,         32'h00000000, 7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000000B3, 1'b1);
    exp_enc  = 16'd0;
    exp_errc = 16'd0;
    for (int i = 0; i < 11; i++) begin
      drive(v[i]);
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL enc%0d_valid got %b exp 1", i, out_valid); end
      n_cmp++; if (instr !== v[i].exp_instr) begin n_fail++; $display("FAIL enc%0d_instr got %h exp %h", i, instr, v[i].exp_instr); end
      n_cmp++; if (imm_err !== v[i].exp_err) begin n_fail++; $display("FAIL enc%0d_imm_err got %b exp %b", i, imm_err, v[i].exp_err); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_enc  = exp_enc + 16'd1;
      exp_errc = exp_errc + 16'(v[i].exp_err);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL enc%0d_drained got %b exp 0", i, out_valid); end
      n_cmp++; if (instr !== 32'd0) begin n_fail++; $display("FAIL enc%0d_idle_instr got %h exp 0", i, instr); end
      n_cmp++; if (enc_cnt !== exp_enc) begin n_fail++; $display("FAIL enc%0d_enc_cnt got %0d exp %0d", i, enc_cnt, exp_enc); end
      n_cmp++; if (err_cnt !== exp_errc) begin n_fail++; $display("FAIL enc%0d_err_cnt got %0d exp %0d", i, err_cnt, exp_errc); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b, c;
    a = mk(`Imm_I_type, 32'hFFFFFFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00093, 1'b0);
    b = mk(`Imm_no,     32'h00000000, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h403100B3, 1'b0);
    c = mk(`Imm_J_type, 32'h00000008, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h008000EF, 1'b0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    drive(a); in_valid = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got %b exp 1", in_ready); end
    n_cmp++; if (instr !== a.exp_instr) begin n_fail++; $display("FAIL b2b_head1 got %h exp %h", instr, a.exp_instr); end
    drive(b);
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got %b exp 0", in_ready); end
    drive(c);
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_held got %b exp 0", in_ready); end
    n_cmp++; if (instr !== a.exp_instr) begin n_fail++; $display("FAIL b2b_head_held got %h exp %h", instr, a.exp_instr); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (instr !== b.exp_instr) begin n_fail++; $display("FAIL b2b_word2 got %h exp %h", instr, b.exp_instr); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (instr !== c.exp_instr) begin n_fail++; $display("FAIL b2b_word3 got %h exp %h", instr, c.exp_instr); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_pushpop got %b exp 1", out_valid); end
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
    n_cmp++; if (enc_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_enc_cnt got %0d exp 3", enc_cnt); end
  endtask

  task automatic test_reset_mid();
    vec_t a;
    a = mk(`Imm_U_type, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h123452B7, 1'b0);
    drive(a); in_valid = 1'b1; out_ready = 1'b0;
    step(); step();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_two_buffered got %b exp 0", in_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (instr !== 32'd0) begin n_fail++; $display("FAIL mid_instr got %h exp 0", instr); end
    n_cmp++; if (enc_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_enc_cnt got %0d exp 0", enc_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_dropped got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_encodings();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
